// File: rtl/tlc5940_gs_shifter_if.sv
// Frame-source side of the TLC5940 grayscale shifter: one word per lane per
// requested channel, valid/ready handshake, channel index supplied by the shifter.
interface tlc5940_gs_shifter_if #(
    parameter int LANES    = 13,
    parameter int GS_BITS  = 12,
    parameter int CHANNELS = 16
);
    logic [LANES*GS_BITS-1:0]     gs_data;
    logic                         gs_valid;
    logic                         gs_ready;
    logic [$clog2(CHANNELS)-1:0]  gs_channel;

    modport master (output gs_data, output gs_valid, input gs_ready, input gs_channel);
    modport slave  (input gs_data, input gs_valid, output gs_ready, output gs_channel);
endinterface

// File: rtl/tlc5940_gs_shifter.sv
// TLC5940 daisy-chain driver: shifts one frame of grayscale words into all
// lanes in parallel, runs the free GS clock / BLANK window and issues XLAT
// inside BLANK once a complete frame is waiting.
//
// Shift FSM
//   state      | meaning
//   SH_IDLE    | between frames, channel index parked at 15
//   SH_LOAD    | gs_ready high, waiting for the next channel word
//   SH_SHIFT   | 12 bits x (A: data out, B: sclk high + shift)
//   SH_PENDING | whole frame shifted, waiting for the latch slot
// GS FSM
//   state      | meaning
//   GS_RUN     | gsclk toggling, 4096 GS clocks per period
//   GS_BLANK   | blank high for BLANK_CYCLES, latch slot at index 1
module tlc5940_gs_shifter #(
    parameter int LANES        = 13,
    parameter int CHANNELS     = 16,
    parameter int GS_BITS      = 12,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    tlc5940_gs_shifter_if.slave    gs_if,
    output logic                   led_sclk,
    output logic [LANES-1:0]       led_sin,
    output logic                   led_xlat,
    output logic                   led_blank,
    output logic                   led_gsclk,
    output logic                   led_mode,
    input  logic                   led_xerr,
    output logic                   frame_done,
    output logic                   xerr_seen
);
    localparam int CH_W   = $clog2(CHANNELS);
    localparam int BIT_W  = $clog2(GS_BITS);
    localparam int BIDX_W = $clog2(BLANK_CYCLES);

    typedef enum logic [1:0] {SH_IDLE, SH_LOAD, SH_SHIFT, SH_PENDING} sh_state_t;
    typedef enum logic {GS_RUN, GS_BLANK} gs_state_t;

    sh_state_t                       sh_state_q;
    logic                            ready_q;
    logic [CH_W-1:0]                 chan_q;
    logic [LANES-1:0][GS_BITS-1:0]   sr_q;
    logic [LANES-1:0]                sin_q;
    logic                            sclk_q;
    logic                            phase_q;
    logic [BIT_W-1:0]                bit_q;
    logic                            done_q;

    gs_state_t                       gs_state_q;
    logic [GS_BITS-1:0]              cnt_q;
    logic [BIDX_W-1:0]               bidx_q;
    logic                            gsclk_q;
    logic                            blank_q;
    logic                            xlat_q;
    logic                            xlat_d;

    logic                            xerr_meta_q;
    logic                            xerr_sync_q;
    logic                            xerr_seen_q;

    logic [LANES-1:0][GS_BITS-1:0]   word_in;

    assign word_in = gs_if.gs_data;

    // XLAT is armed only if the frame was already pending during BLANK index 0,
    // so a frame that completes exactly at the slot waits for the next BLANK.
    always_comb begin
        xlat_d = (gs_state_q == GS_BLANK) && (bidx_q == '0) && (sh_state_q == SH_PENDING);
    end

    // Shift FSM: word capture, two-cycle bit serialisation, wait for latch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sh_state_q <= SH_IDLE;
            ready_q    <= 1'b0;
            chan_q     <= CH_W'(CHANNELS-1);
            sr_q       <= '0;
            sin_q      <= '0;
            sclk_q     <= 1'b0;
            phase_q    <= 1'b0;
            bit_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (sh_state_q)
                SH_IDLE: begin
                    sh_state_q <= SH_LOAD;
                    ready_q    <= 1'b1;
                end
                SH_LOAD: begin
                    if (gs_if.gs_valid) begin
                        sr_q <= word_in;
                        for (int k = 0; k < LANES; k++) begin
                            sin_q[k] <= word_in[k][GS_BITS-1];
                        end
                        ready_q    <= 1'b0;
                        phase_q    <= 1'b0;
                        bit_q      <= BIT_W'(GS_BITS-1);
                        sh_state_q <= SH_SHIFT;
                    end
                end
                SH_SHIFT: begin
                    if (!phase_q) begin
                        sclk_q  <= 1'b1;
                        phase_q <= 1'b1;
                    end else begin
                        sclk_q  <= 1'b0;
                        phase_q <= 1'b0;
                        for (int k = 0; k < LANES; k++) begin
                            sr_q[k] <= {sr_q[k][GS_BITS-2:0], 1'b0};
                        end
                        if (bit_q == '0) begin
                            // last bit: sin holds its value until the next word arrives
                            chan_q <= (chan_q == '0) ? CH_W'(CHANNELS-1) : chan_q - 1'b1;
                            if (chan_q == '0) begin
                                sh_state_q <= SH_PENDING;
                            end else begin
                                sh_state_q <= SH_LOAD;
                                ready_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q - 1'b1;
                            for (int k = 0; k < LANES; k++) begin
                                sin_q[k] <= sr_q[k][GS_BITS-2];
                            end
                        end
                    end
                end
                SH_PENDING: begin
                    if (xlat_q) begin
                        sh_state_q <= SH_IDLE;
                        done_q     <= 1'b1;
                    end
                end
                default: sh_state_q <= SH_IDLE;
            endcase
        end
    end

    // GS FSM: free-running gsclk, BLANK window and the XLAT pulse.
    // cnt_q counts completed GS clock periods; the 4096th high phase ends RUN.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gs_state_q <= GS_BLANK;
            cnt_q      <= '0;
            bidx_q     <= '0;
            gsclk_q    <= 1'b0;
            blank_q    <= 1'b1;
            xlat_q     <= 1'b0;
        end else begin
            xlat_q <= xlat_d;
            case (gs_state_q)
                GS_RUN: begin
                    if (!gsclk_q) begin
                        gsclk_q <= 1'b1;
                    end else begin
                        gsclk_q <= 1'b0;
                        if (cnt_q == '1) begin
                            gs_state_q <= GS_BLANK;
                            blank_q    <= 1'b1;
                            bidx_q     <= '0;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                GS_BLANK: begin
                    if (bidx_q == BIDX_W'(BLANK_CYCLES-1)) begin
                        gs_state_q <= GS_RUN;
                        blank_q    <= 1'b0;
                        cnt_q      <= '0;
                    end else begin
                        bidx_q <= bidx_q + 1'b1;
                    end
                end
                default: gs_state_q <= GS_BLANK;
            endcase
        end
    end

    // XERR is asynchronous open-drain: two-flop synchroniser and sticky flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xerr_meta_q <= 1'b1;
            xerr_sync_q <= 1'b1;
            xerr_seen_q <= 1'b0;
        end else begin
            xerr_meta_q <= led_xerr;
            xerr_sync_q <= xerr_meta_q;
            if (!xerr_sync_q) begin
                xerr_seen_q <= 1'b1;
            end
        end
    end

    assign gs_if.gs_ready   = ready_q;
    assign gs_if.gs_channel = chan_q;
    assign led_sclk         = sclk_q;
    assign led_sin          = sin_q;
    assign led_xlat         = xlat_q;
    assign led_blank        = blank_q;
    assign led_gsclk        = gsclk_q;
    assign led_mode         = 1'b0;
    assign frame_done       = done_q;
    assign xerr_seen        = xerr_seen_q;
endmodule

// File: tb/tb_tlc5940_gs_shifter.sv
// Directed bench for tlc5940_gs_shifter: reset, single frame, backpressure,
// no-data BLANK cadence, XERR sticky flag and reset in the middle of a frame.
module tb_tlc5940_gs_shifter;
    localparam int LANES = 13;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             led_sclk;
    logic [LANES-1:0] led_sin;
    logic             led_xlat;
    logic             led_blank;
    logic             led_gsclk;
    logic             led_mode;
    logic             led_xerr;
    logic             frame_done;
    logic             xerr_seen;

    tlc5940_gs_shifter_if #(.LANES(LANES), .GS_BITS(12), .CHANNELS(16)) gs_if ();

    tlc5940_gs_shifter #(.LANES(LANES), .CHANNELS(16), .GS_BITS(12), .BLANK_CYCLES(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .gs_if      (gs_if),
        .led_sclk   (led_sclk),
        .led_sin    (led_sin),
        .led_xlat   (led_xlat),
        .led_blank  (led_blank),
        .led_gsclk  (led_gsclk),
        .led_mode   (led_mode),
        .led_xerr   (led_xerr),
        .frame_done (frame_done),
        .xerr_seen  (xerr_seen)
    );

    always #5 clock = ~clock;

    // Frame content: lane 0 channel 15 = 0xABC, lane 12 channel 0 = 0x5A3, rest 0.
    always_comb begin
        gs_if.gs_data = '0;
        if (gs_if.gs_channel == 4'd15) gs_if.gs_data[11:0] = 12'hABC;
        if (gs_if.gs_channel == 4'd0)  gs_if.gs_data[144 +: 12] = 12'h5A3;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Observers updated on every falling edge
    int           cyc = 0;
    int           rises = 0;
    logic [191:0] s0 = '0;
    logic [191:0] s12 = '0;
    int           bidx = 0;
    int           blank_rises = 0;
    int           t_last = 0;
    int           t_prev = 0;
    int           xlat_cnt = 0;
    int           xlat_bidx = -1;
    int           xlat_bad = 0;
    int           fd_cnt = 0;
    int           fd_bad = 0;
    int           sin_bad = 0;
    logic         sclk_prev = 1'b0;
    logic         blank_prev = 1'b1;
    logic         xlat_prev = 1'b0;
    logic [LANES-1:0] sin_prev = '0;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (led_sclk && !sclk_prev) begin
            rises = rises + 1;
            s0  = {s0[190:0], led_sin[0]};
            s12 = {s12[190:0], led_sin[12]};
            if (led_sin !== sin_prev) sin_bad = sin_bad + 1;
        end
        if (led_blank) bidx = blank_prev ? bidx + 1 : 0;
        if (led_blank && !blank_prev) begin
            t_prev = t_last;
            t_last = cyc;
            blank_rises = blank_rises + 1;
        end
        if (led_xlat) begin
            xlat_cnt = xlat_cnt + 1;
            xlat_bidx = bidx;
            if (!led_blank || led_sclk || xlat_prev) xlat_bad = xlat_bad + 1;
        end
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            if (!xlat_prev) fd_bad = fd_bad + 1;
        end
        sclk_prev  = led_sclk;
        blank_prev = led_blank;
        xlat_prev  = led_xlat;
        sin_prev   = led_sin;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    initial begin
        logic [191:0] exp0;
        logic [191:0] exp12;
        int n, r0, r1, r2, x0, b0, f0;
        logic got;

        exp0  = {12'hABC, 180'd0};
        exp12 = {180'd0, 12'h5A3};

        // Reset held with valid asserted
        reset_n = 1'b0;
        led_xerr = 1'b1;
        gs_if.gs_valid = 1'b1;
        repeat (3) step();
        chk("rst_blank", led_blank, 1);
        chk("rst_gsclk", led_gsclk, 0);
        chk("rst_sclk", led_sclk, 0);
        chk("rst_sin", led_sin, 0);
        chk("rst_xlat", led_xlat, 0);
        chk("rst_ready", gs_if.gs_ready, 0);
        chk("rst_channel", gs_if.gs_channel, 15);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_xerr_seen", xerr_seen, 0);
        chk("rst_mode", led_mode, 0);

        // Release: first gsclk rise five clocks later
        reset_n = 1'b1;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clock);
            #1;
            n++;
            if (led_gsclk) got = 1'b1;
        end
        chk("first_gsclk_delay", n, 5);

        // Single frame, valid held high
        got = 1'b0;
        for (int i = 0; i < 10000 && !got; i++) begin
            step();
            if (frame_done) got = 1'b1;
        end
        chk("f1_done_seen", got, 1);
        chk("f1_sclk_rises", rises, 192);
        chk("f1_first12", s0[191:180], 12'hABC);
        chk("f1_lane0", s0, exp0);
        chk("f1_lane12", s12, exp12);
        chk("f1_xlat_count", xlat_cnt, 1);
        chk("f1_xlat_blank_idx", xlat_bidx, 1);
        chk("f1_xlat_bad", xlat_bad, 0);
        chk("f1_fd_count", fd_cnt, 1);
        chk("f1_fd_after_xlat", fd_bad, 0);
        chk("f1_sin_stable", sin_bad, 0);

        // Backpressure: 50-cycle gap in a LOAD slot mid-frame
        r0 = rises;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            step();
            if ((rises - r0) >= 100 && gs_if.gs_ready) got = 1'b1;
        end
        chk("bp_reach_load", got, 1);
        gs_if.gs_valid = 1'b0;
        r1 = rises;
        repeat (50) step();
        chk("bp_gap_rises", rises - r1, 0);
        chk("bp_gap_ready", gs_if.gs_ready, 1);
        chk("bp_gap_sclk", led_sclk, 0);
        gs_if.gs_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10000 && !got; i++) begin
            step();
            if (frame_done) got = 1'b1;
        end
        chk("bp_done_seen", got, 1);
        gs_if.gs_valid = 1'b0;
        chk("bp_sclk_rises", rises - r0, 192);
        chk("bp_lane0", s0, exp0);
        chk("bp_lane12", s12, exp12);
        chk("bp_xlat_count", xlat_cnt, 2);
        chk("bp_xlat_blank_idx", xlat_bidx, 1);
        chk("bp_gs_period", t_last - t_prev, 8196);
        chk("bp_blank_rises", blank_rises, 2);
        chk("bp_sin_stable", sin_bad, 0);

        // No data: BLANK keeps its cadence, no XLAT
        x0 = xlat_cnt;
        b0 = blank_rises;
        r2 = rises;
        got = 1'b0;
        for (int i = 0; i < 9000 && !got; i++) begin
            step();
            if (blank_rises > b0) got = 1'b1;
        end
        chk("nd_blank_seen", got, 1);
        repeat (10) step();
        chk("nd_gs_period", t_last - t_prev, 8196);
        chk("nd_xlat_none", xlat_cnt, x0);
        chk("nd_no_sclk", rises, r2);
        chk("nd_ready", gs_if.gs_ready, 1);
        chk("nd_channel", gs_if.gs_channel, 15);
        chk("nd_xlat_bad", xlat_bad, 0);

        // XERR: one-cycle low pulse, seen within three clocks, sticky
        chk("xerr_before", xerr_seen, 0);
        led_xerr = 1'b0;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clock);
            #1;
            led_xerr = 1'b1;
            n++;
            if (xerr_seen) got = 1'b1;
        end
        chk("xerr_latency", n, 3);
        repeat (20) step();
        chk("xerr_sticky", xerr_seen, 1);

        // Reset after 100 sclk rises, then a full new frame
        gs_if.gs_valid = 1'b1;
        r0 = rises;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            step();
            if ((rises - r0) >= 100) got = 1'b1;
        end
        chk("mr_reach_100", got, 1);
        reset_n = 1'b0;
        step();
        chk("mr_xerr_cleared", xerr_seen, 0);
        chk("mr_blank", led_blank, 1);
        chk("mr_sclk", led_sclk, 0);
        chk("mr_channel", gs_if.gs_channel, 15);
        repeat (2) step();
        reset_n = 1'b1;
        r1 = rises;
        x0 = xlat_cnt;
        f0 = fd_cnt;
        got = 1'b0;
        for (int i = 0; i < 10000 && !got; i++) begin
            step();
            if (xlat_cnt > x0) got = 1'b1;
        end
        chk("mr_xlat_seen", got, 1);
        chk("mr_sclk_rises", rises - r1, 192);
        chk("mr_lane0", s0, exp0);
        chk("mr_lane12", s12, exp12);
        chk("mr_xlat_blank_idx", xlat_bidx, 1);
        repeat (2) step();
        chk("mr_fd_count", fd_cnt - f0, 1);
        chk("mr_xlat_bad", xlat_bad, 0);
        chk("mr_fd_after_xlat", fd_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tlc5940_gs_shifter.md
# tlc5940_gs_shifter

Serialises one frame of 12-bit grayscale values into the parallel TLC5940 daisy-chains (six left, six right, one calibration lane). It also generates the free-running grayscale clock, the BLANK window and the XLAT latch pulse. It sits between the frame source (valid/ready word stream) and the `led_*` pins of `toplevel`, and drives them directly.

## Interface
- `LANES`, 13: parallel serial lanes; bit 0..5 = `led_l_sin[1..6]`, 6..11 = `led_r_sin[1..6]`, 12 = `led_cal_sin`.
- `CHANNELS`, 16: channels per lane, one driver per lane.
- `GS_BITS`, 12: grayscale bits per channel.
- `BLANK_CYCLES`, 4: clock cycles BLANK is held between GS cycles; minimum 3.

- `clock`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `gs_data`  in  LANES*GS_BITS  one channel word for every lane; lane k occupies bits [k*12+11:k*12].
- `gs_valid`  in  1  `gs_data` is valid.
- `gs_ready`  out  1  block accepts `gs_data` this cycle.
- `gs_channel`  out  4  channel index being requested; 15 first, down to 0.
- `led_sclk`  out  1  serial shift clock.
- `led_sin`  out  LANES  serial data, MSB first.
- `led_xlat`  out  1  latch pulse.
- `led_blank`  out  1  outputs off / GS counter reset.
- `led_gsclk`  out  1  grayscale clock.
- `led_mode`  out  1  constant 0 (grayscale mode only).
- `led_xerr`  in  1  open-drain error from drivers, active-low, asynchronous.
- `frame_done`  out  1  one-cycle pulse when a frame has been latched.
- `xerr_seen`  out  1  sticky error flag.

## Operation
- Shift FSM: IDLE → LOAD → SHIFT → PENDING → IDLE.
  - IDLE: enter LOAD the cycle after reset release and the cycle after each latch. `gs_channel` is 15.
  - LOAD: `gs_ready`=1. A transfer occurs when `gs_valid`&&`gs_ready`. Capture the word into per-lane 12-bit shift registers, then go to SHIFT.
  - SHIFT: emit 12 bits, each taking two cycles.
    - Cycle A: `led_sin` = register MSB; `led_sclk`=0.
    - Cycle B: `led_sclk`=1; shift register left.
    - After bit 0: decrement `gs_channel`. If it was 0, go to PENDING; otherwise go to LOAD.
  - PENDING: hold `led_sclk`=0 and wait for the latch slot.
- GS FSM: RUN ↔ BLANK.
  - RUN: `led_gsclk` toggles every cycle. A 12-bit counter increments on each gsclk rising edge. After the 4096th rising edge, `led_gsclk` goes low and the FSM enters BLANK.
  - BLANK: `led_blank`=1 for `BLANK_CYCLES` cycles and `led_gsclk`=0. Return to RUN with the counter cleared.
  - Latch slot: BLANK cycle index 1, counting from 0. If the shift FSM is in PENDING during that cycle, `led_xlat`=1 for exactly that cycle, and on the next cycle `frame_done`=1 and the shift FSM goes to IDLE.
  - An empty BLANK (no PENDING frame) redisplays the previous data. No XLAT is issued.
- Backpressure: when `gs_valid`=0 in LOAD, `led_sclk` stays 0, `led_sin` holds and the GS FSM is unaffected.
- XERR: synchronise through two flops. A low sample sets `xerr_seen`; only reset clears it.
- `led_mode` is always 0. The block never issues the extra post-DC-mode SCLK.

## Timing
- Reset values:
  - `led_blank`=1; all other outputs 0.
  - `gs_channel`=15.
  - GS FSM starts in BLANK with its cycle index at 0, so the first RUN begins `BLANK_CYCLES` cycles after release.
- Minimum frame shift time with `gs_valid` held high is 16×(1 LOAD + 24 SHIFT) = 400 cycles.
- GS period is 8192 RUN cycles + `BLANK_CYCLES`.
- Output timing guarantees:
  - `led_sin` is stable for at least 1 cycle before and through each `led_sclk` high.
  - `led_xlat` is asserted only while `led_blank`=1, never in the first or last BLANK cycle.
  - `led_sclk` is 0 whenever `led_xlat`=1.
- Simultaneous events: PENDING reached in the same cycle as the latch slot → latch in the next BLANK, not this one.
- Reset mid-operation: all state aborts immediately to reset values. A partial frame is discarded and never latched.

## Test plan
- Reset: hold `reset_n`=0 with `gs_valid`=1 → `led_blank`=1, all other outputs 0, `gs_channel`=15. Release → first `led_gsclk` rise 5 cycles later (BLANK_CYCLES=4).
- Single frame:
  - Stimulus: lane 0 channel 15 = 0xABC, all other words 0, `gs_valid` held 1.
  - Required response:
    - First 12 `led_sin[0]` bits sampled at `led_sclk` rises are 1010_1011_1100.
    - 192 sclk rises in total.
    - `led_xlat` pulses once, in BLANK cycle index 1.
    - `frame_done` follows the XLAT cycle.
- Backpressure: drop `gs_valid` for 50 cycles mid-frame → no sclk edges during the gap. Serial stream is identical to the unstalled case. GS period remains 8196 cycles.
- No data: never assert `gs_valid` → `led_blank` pulses every 8196 cycles and `led_xlat` stays 0.
- XERR: drive `led_xerr`=0 for 1 cycle → `xerr_seen`=1 within 3 cycles, and it stays 1 after `led_xerr` returns to 1 until reset.
- Reset mid-shift: assert `reset_n`=0 after 100 sclk rises, then send a full new frame → exactly 192 sclk rises before the next `led_xlat`.
